// File: rtl/lbc_pkg.sv
// Shared types and helpers for the line buffer controller.
// Holds the sequencing state enum, err bit positions and the counter width helper.
package lbc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StFill0,
    StFill1,
    StRun,
    StDone
  } lbc_state_e;

  localparam int unsigned ErrDrop  = 0;
  localparam int unsigned ErrUnder = 1;

  // Minimum counter width able to hold a column index for the given line length.
  function automatic int unsigned lbc_cnt_w(input int unsigned img_width);
    return (img_width < 2) ? 1 : $clog2(img_width);
  endfunction

endpackage

// File: rtl/lbc_pos_cnt.sv
// Column/row position counter for the line buffer controller.
// Wraps col at IMG_WIDTH-1 and row at IMG_HEIGHT-1; eol/eof strobe on the accepted pixel.
module lbc_pos_cnt
  import lbc_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             eol,
  output logic             eof
);

  localparam logic [CNT_W-1:0] ColLast = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] RowLast = CNT_W'(IMG_HEIGHT - 1);

  if (lbc_cnt_w(IMG_WIDTH) > CNT_W) begin : g_width_check
    $error("CNT_W too narrow for IMG_WIDTH");
  end

  logic [CNT_W-1:0] col_q, row_q;

  assign col = col_q;
  assign row = row_q;
  assign eol = inc && (col_q == ColLast);
  assign eof = eol && (row_q == RowLast);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (inc) begin
      if (eol) begin
        col_q <= '0;
        row_q <= eof ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Two-FIFO cascaded line delay sequencer producing three column-aligned row taps.
// Define LBC_BORDER_REPLICATE_EN to also emit taps for lines 0 and 1 with replicated rows.
module line_buffer_ctrl
  import lbc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMG_WIDTH    = 640,
  parameter int unsigned IMG_HEIGHT   = 480,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  pix_vld,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  fifo_rst,
  output logic                  f0_wr_en,
  output logic [DATA_WIDTH-1:0] f0_wr_data,
  output logic                  f0_rd_en,
  input  logic [DATA_WIDTH-1:0] f0_rd_data,
  input  logic                  f0_full,
  input  logic                  f0_empty,
  output logic                  f1_wr_en,
  output logic [DATA_WIDTH-1:0] f1_wr_data,
  output logic                  f1_rd_en,
  input  logic [DATA_WIDTH-1:0] f1_rd_data,
  input  logic                  f1_full,
  input  logic                  f1_empty,
  output logic                  tap_vld,
  output logic [DATA_WIDTH-1:0] tap_row0,
  output logic [DATA_WIDTH-1:0] tap_row1,
  output logic [DATA_WIDTH-1:0] tap_row2,
  output logic [CNT_W-1:0]      tap_col,
  output logic [CNT_W-1:0]      tap_row,
  output logic                  busy,
  output logic [1:0]            err
);

  localparam logic [7:0] FlushLast = 8'(FLUSH_CYCLES - 1);

  lbc_state_e state_q, state_d, d_state_q;
  logic [7:0] flush_cnt_q, flush_cnt_d;
  logic       fifo_rst_q, busy_q, tap_vld_q;
  logic [1:0] err_q;
  logic [CNT_W-1:0] col, row, d_col_q, d_row_q;
  logic       eol, eof;
  logic       in_line, acc, drop, f0_rd_req, f1_rd_req, f1_wr_req, tap_en, tap_vld_d;
  logic       d_vld_q;
  logic [DATA_WIDTH-1:0] d_data_q, row0_d, row1_d;

  assign in_line   = state_q inside {StFill0, StFill1, StRun};
  assign acc       = pix_vld && !sof && in_line;
  assign drop      = pix_vld && (sof || (state_q == StFlush));
  assign f0_rd_req = acc && (state_q inside {StFill1, StRun});
  assign f1_rd_req = acc && (state_q == StRun);
  // Line 0 never reaches f1; later lines follow one cycle behind the f0 read.
  assign f1_wr_req = d_vld_q && (d_state_q inside {StFill1, StRun});

  assign f0_wr_en   = acc && !f0_full;
  assign f0_rd_en   = f0_rd_req && !f0_empty;
  assign f1_wr_en   = f1_wr_req && !f1_full;
  assign f1_rd_en   = f1_rd_req && !f1_empty;
  assign f0_wr_data = pix_data;
  assign f1_wr_data = f0_rd_data;

`ifdef LBC_BORDER_REPLICATE_EN
  assign tap_en = 1'b1;
  assign row1_d = (d_state_q == StFill0) ? d_data_q : f0_rd_data;
  assign row0_d = (d_state_q == StFill0) ? d_data_q :
                  (d_state_q == StFill1) ? f0_rd_data : f1_rd_data;
`else
  assign tap_en = (d_state_q == StRun);
  assign row1_d = f0_rd_data;
  assign row0_d = f1_rd_data;
`endif

  // sof kills the pipeline so an aborted frame leaves no taps behind.
  assign tap_vld_d = d_vld_q && tap_en && !sof;

  lbc_pos_cnt #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .CNT_W     (CNT_W)
  ) u_pos_cnt (
    .clk(clk),
    .rst(rst),
    .clr(sof || (state_q == StFlush)),
    .inc(acc),
    .col(col),
    .row(row),
    .eol(eol),
    .eof(eof)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (sof && (state_q != StFlush)) begin
      state_d     = StFlush;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        StFlush: begin
          if (flush_cnt_q == FlushLast) state_d = StFill0;
          else flush_cnt_d = flush_cnt_q + 8'd1;
        end
        StFill0: if (eol) state_d = StFill1;
        StFill1: if (eol) state_d = StRun;
        StRun:   if (eof) state_d = StDone;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFlush;
      flush_cnt_q <= '0;
      fifo_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      fifo_rst_q  <= (state_d == StFlush);
      busy_q      <= (state_d inside {StFlush, StFill0, StFill1, StRun}) || acc || tap_vld_d;
      err_q[ErrDrop]  <= err_q[ErrDrop] | drop | (acc && f0_full) | (f1_wr_req && f1_full);
      err_q[ErrUnder] <= err_q[ErrUnder] | (f0_rd_req && f0_empty) | (f1_rd_req && f1_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_vld_q   <= 1'b0;
      d_state_q <= StIdle;
      d_data_q  <= '0;
      d_col_q   <= '0;
      d_row_q   <= '0;
      tap_vld_q <= 1'b0;
      tap_row0  <= '0;
      tap_row1  <= '0;
      tap_row2  <= '0;
      tap_col   <= '0;
      tap_row   <= '0;
    end else begin
      d_vld_q   <= acc;
      d_state_q <= state_q;
      d_data_q  <= pix_data;
      d_col_q   <= col;
      d_row_q   <= row;
      tap_vld_q <= tap_vld_d;
      if (tap_vld_d) begin
        tap_row0 <= row0_d;
        tap_row1 <= row1_d;
        tap_row2 <= d_data_q;
        tap_col  <= d_col_q;
        tap_row  <= d_row_q;
      end
    end
  end

  assign fifo_rst = fifo_rst_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign tap_vld  = tap_vld_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl on a 4x4 image with behavioural FIFOs.
// Expected taps come from the image array: (line r-2, line r-1, line r) per column.
module tb_line_buffer_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned CW = 12;

  logic clk = 1'b0;
  logic tb_rst;
  always #5 clk = ~clk;

  logic          sof, pix_vld;
  logic [DW-1:0] pix_data;
  logic          fifo_rst;
  logic          f0_wr_en, f0_rd_en, f0_full, f0_empty;
  logic          f1_wr_en, f1_rd_en, f1_full, f1_empty;
  logic [DW-1:0] f0_wr_data, f0_rd_data, f1_wr_data, f1_rd_data;
  logic          tap_vld, busy;
  logic [DW-1:0] tap_row0, tap_row1, tap_row2;
  logic [CW-1:0] tap_col, tap_row;
  logic [1:0]    err;

  line_buffer_ctrl #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .CNT_W       (CW),
    .FLUSH_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (tb_rst),
    .sof       (sof),
    .pix_vld   (pix_vld),
    .pix_data  (pix_data),
    .fifo_rst  (fifo_rst),
    .f0_wr_en  (f0_wr_en),
    .f0_wr_data(f0_wr_data),
    .f0_rd_en  (f0_rd_en),
    .f0_rd_data(f0_rd_data),
    .f0_full   (f0_full),
    .f0_empty  (f0_empty),
    .f1_wr_en  (f1_wr_en),
    .f1_wr_data(f1_wr_data),
    .f1_rd_en  (f1_rd_en),
    .f1_rd_data(f1_rd_data),
    .f1_full   (f1_full),
    .f1_empty  (f1_empty),
    .tap_vld   (tap_vld),
    .tap_row0  (tap_row0),
    .tap_row1  (tap_row1),
    .tap_row2  (tap_row2),
    .tap_col   (tap_col),
    .tap_row   (tap_row),
    .busy      (busy),
    .err       (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFOs: 1-cycle read latency, depth 4096.
  logic [DW-1:0] q0[$], q1[$];
  int n0 = 0;
  int n1 = 0;
  logic force_e0 = 1'b0;
  assign f0_empty = force_e0 || (n0 == 0);
  assign f0_full  = (n0 >= 4096);
  assign f1_empty = (n1 == 0);
  assign f1_full  = (n1 >= 4096);

  always @(posedge clk) begin
    if (fifo_rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (f0_rd_en && q0.size() > 0) f0_rd_data <= q0.pop_front();
      if (f0_wr_en) q0.push_back(f0_wr_data);
      if (f1_rd_en && q1.size() > 0) f1_rd_data <= q1.pop_front();
      if (f1_wr_en) q1.push_back(f1_wr_data);
    end
    n0 <= q0.size();
    n1 <= q1.size();
  end

  typedef struct {
    logic [DW-1:0] r0, r1, r2;
    int col, row, cyc;
  } tap_t;

  tap_t cap[$], exp_q[$];

  always @(negedge clk)
    if (tap_vld === 1'b1)
      cap.push_back('{tap_row0, tap_row1, tap_row2, int'(tap_col), int'(tap_row), cyc});

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
    @(negedge clk);
    pix_vld  = v;
    pix_data = d;
    sof      = s;
  endtask

  task automatic test_reset;
    int cnt;
    tb_rst = 1'b1; sof = 1'b0; pix_vld = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    tests++; if (fifo_rst !== 1'b1) begin fails++; $display("FAIL reset fifo_rst: got %b want 1", fifo_rst); end
    tests++; if (tap_vld !== 1'b0) begin fails++; $display("FAIL reset tap_vld: got %b want 0", tap_vld); end
    tests++; if (err !== 2'b00) begin fails++; $display("FAIL reset err: got %b want 00", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    tb_rst = 1'b0;
    repeat (6) drive(1'b0, '0, 1'b0);
    tests++; if (fifo_rst !== 1'b0) begin fails++; $display("FAIL post-flush fifo_rst: got %b want 0", fifo_rst); end
    drive(1'b0, '0, 1'b1);
    cnt = 0;
    repeat (8) begin
      drive(1'b0, '0, 1'b0);
      if (fifo_rst === 1'b1) cnt++;
    end
    tests++; if (cnt != 4) begin fails++; $display("FAIL sof flush length: got %0d want 4", cnt); end
    drive(1'b1, 8'hA5, 1'b0);
    #1;
    tests++;
    if (f0_wr_en !== 1'b1 || f0_rd_en !== 1'b0 || f0_wr_data !== 8'hA5) begin
      fails++;
      $display("FAIL fill0 strobes: got wr %b rd %b data %h want wr 1 rd 0 data a5",
               f0_wr_en, f0_rd_en, f0_wr_data);
    end
    drive(1'b0, '0, 1'b0);
  endtask

  // mode 0: continuous, 1: valid toggling 1/0, 2: random gaps.  seq: data = r*W+c.
  task automatic test_frame(input int mode, input bit seq, input string name);
    logic [DW-1:0] img [H][W];
    int px;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = seq ? DW'(r * W + c) : DW'($urandom);
    cap.delete();
    exp_q.delete();
    drive(1'b0, '0, 1'b1);
    repeat (4) drive(1'b0, '0, 1'b0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s busy in frame: got %b want 1", name, busy); end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (mode == 2) repeat ($urandom_range(0, 2)) drive(1'b0, '0, 1'b0);
        drive(1'b1, img[r][c], 1'b0);
        px = cyc;
`ifdef LBC_BORDER_REPLICATE_EN
        if (r == 0) exp_q.push_back('{img[r][c], img[r][c], img[r][c], c, r, px + 2});
        else if (r == 1) exp_q.push_back('{img[0][c], img[0][c], img[1][c], c, r, px + 2});
        else exp_q.push_back('{img[r-2][c], img[r-1][c], img[r][c], c, r, px + 2});
`else
        if (r >= 2) exp_q.push_back('{img[r-2][c], img[r-1][c], img[r][c], c, r, px + 2});
`endif
        if (mode == 1) drive(1'b0, '0, 1'b0);
      end
    end
    repeat (6) drive(1'b0, '0, 1'b0);
    tests++;
    if (cap.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s tap count: got %0d want %0d", name, cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      tests++;
      if (cap[i].r0 !== exp_q[i].r0 || cap[i].r1 !== exp_q[i].r1 || cap[i].r2 !== exp_q[i].r2 ||
          cap[i].col != exp_q[i].col || cap[i].row != exp_q[i].row || cap[i].cyc != exp_q[i].cyc) begin
        fails++;
        $display("FAIL %s tap %0d: got (%0d,%0d,%0d) col %0d row %0d cyc %0d want (%0d,%0d,%0d) col %0d row %0d cyc %0d",
                 name, i, cap[i].r0, cap[i].r1, cap[i].r2, cap[i].col, cap[i].row, cap[i].cyc,
                 exp_q[i].r0, exp_q[i].r1, exp_q[i].r2, exp_q[i].col, exp_q[i].row, exp_q[i].cyc);
      end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s busy after frame: got %b want 0", name, busy); end
    tests++; if (err !== 2'b00) begin fails++; $display("FAIL %s err: got %b want 00", name, err); end
  endtask

  task automatic test_abort;
    int sof_cyc, cnt, late;
    cap.delete();
    drive(1'b0, '0, 1'b1);
    repeat (4) drive(1'b0, '0, 1'b0);
    for (int p = 0; p < 2 * W + 2; p++) drive(1'b1, DW'(p), 1'b0);
    drive(1'b0, '0, 1'b1);
    sof_cyc = cyc;
    cnt = 0;
    repeat (8) begin
      drive(1'b0, '0, 1'b0);
      if (fifo_rst === 1'b1) cnt++;
    end
    late = 0;
    foreach (cap[i]) if (cap[i].cyc > sof_cyc) late++;
    tests++; if (late != 0) begin fails++; $display("FAIL abort taps after sof: got %0d want 0", late); end
    tests++; if (cnt != 4) begin fails++; $display("FAIL abort flush length: got %0d want 4", cnt); end
    test_frame(0, 1'b1, "after_abort");
  endtask

  task automatic test_errors;
    drive(1'b0, '0, 1'b1);
    repeat (4) drive(1'b0, '0, 1'b0);
    for (int c = 0; c < W; c++) drive(1'b1, DW'(c), 1'b0);
    force_e0 = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    #1;
    tests++;
    if (f0_rd_en !== 1'b0 || f0_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL forced empty strobes: got rd %b wr %b want rd 0 wr 1", f0_rd_en, f0_wr_en);
    end
    drive(1'b0, '0, 1'b0);
    force_e0 = 1'b0;
    tests++; if (err !== 2'b10) begin fails++; $display("FAIL underflow err: got %b want 10", err); end
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b0, '0, 1'b0);
    tests++; if (err !== 2'b11) begin fails++; $display("FAIL flush drop err: got %b want 11", err); end
    repeat (8) drive(1'b0, '0, 1'b0);
    tests++; if (err !== 2'b11) begin fails++; $display("FAIL err sticky: got %b want 11", err); end
    tb_rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tb_rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    tests++; if (err !== 2'b00) begin fails++; $display("FAIL err after rst: got %b want 00", err); end
    repeat (6) drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame(0, 1'b1, "continuous");
    test_frame(1, 1'b1, "toggle");
    test_frame(2, 1'b0, "random_a");
    test_frame(2, 1'b0, "random_b");
    test_frame(0, 1'b0, "back_to_back");
    test_abort();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequences two external 8-bit fifo_line_buffer instances (depth 4096, non-registered output, 1-cycle read latency) as a cascaded two-line delay for the 3x3 matrix datapath.
- Accepts a raster pixel stream and generates all write, read and reset strobes for both FIFOs.
- Emits three column-aligned row taps plus row/column position to the downstream 3x3 window and filter stage.

Parameters:
- DATA_WIDTH, 8, pixel width; equals FIFO data width.
- IMG_WIDTH, 640, pixels per line; legal range 2..4095.
- IMG_HEIGHT, 480, lines per frame; legal range 3..4095.
- CNT_W, 12, width of the column and row counters.
- FLUSH_CYCLES, 4, number of cycles fifo_rst is held high at frame start.

Ports:
- clk  in  1  system clock; also drives wr_clk and rd_clk of both FIFOs.
- rst  in  1  synchronous, active-high reset.
- sof  in  1  start-of-frame pulse.
- pix_vld  in  1  input pixel valid.
- pix_data  in  DATA_WIDTH  input pixel.
- fifo_rst  out  1  reset to both FIFOs (wr_rst and rd_rst).
- f0_wr_en  out  1  / f0_wr_data  out  DATA_WIDTH  / f0_rd_en  out  1
- f0_rd_data  in  DATA_WIDTH  / f0_full  in  1  / f0_empty  in  1
- f1_wr_en  out  1  / f1_wr_data  out  DATA_WIDTH  / f1_rd_en  out  1
- f1_rd_data  in  DATA_WIDTH  / f1_full  in  1  / f1_empty  in  1
- tap_vld  out  1  taps valid.
- tap_row0  out  DATA_WIDTH  line n-2 (oldest).
- tap_row1  out  DATA_WIDTH  line n-1.
- tap_row2  out  DATA_WIDTH  line n (current).
- tap_col  out  CNT_W  column of the taps.
- tap_row  out  CNT_W  line of tap_row2.
- busy  out  1  frame in progress.
- err  out  2  sticky flags: [0] overflow/drop, [1] underflow.

Behaviour:
- Reset values: all outputs 0 except fifo_rst=1. State FLUSH, flush counter=0.
- States: IDLE, FLUSH, FILL0, FILL1, RUN, DONE.
- IDLE: sof -> FLUSH. pix_vld is ignored.
- FLUSH: fifo_rst=1 for FLUSH_CYCLES cycles, then -> FILL0. Counters cleared. Any pix_vld during FLUSH is dropped and sets err[0].
- FILL0 (line 0): f0_wr_en=pix_vld, f0_wr_data=pix_data. No reads.
- FILL1 (line 1) and RUN (lines >=2): on pix_vld, assert f0_rd_en and f0_wr_en(pix_data) in the same cycle.
- Pipeline alignment: pix_vld, pix_data, col and row are delayed by 1 cycle to match FIFO read latency. On the delayed valid, f1_wr_en=1 with f1_wr_data=f0_rd_data.
- In RUN, f1_rd_en=pix_vld as well.
- Taps: registered one cycle after the delayed valid, giving 2-cycle latency from pix_vld to tap_vld.
  - tap_row2 = delayed pix_data.
  - tap_row1 = f0_rd_data.
  - tap_row0 = f1_rd_data.
  - Without the optional feature, tap_vld is asserted only for pixels of RUN lines.
- Counters: col increments on pix_vld and wraps IMG_WIDTH-1 -> 0; the wrap increments row.
- Line transitions: FILL0 -> FILL1 at end of line 0. FILL1 -> RUN at end of line 1.
- End of frame: when the last pixel of line IMG_HEIGHT-1 is accepted -> DONE. The FIFOs then hold two residual lines, which are discarded. busy drops once the final tap has been emitted. DONE -> FLUSH on sof.
- sof in any state other than FLUSH aborts the frame: -> FLUSH immediately. Pipeline valids are cleared, so no tap_vld is emitted for the aborted frame.
- sof and pix_vld in the same cycle: sof wins, and the pixel is dropped (err[0] set).
- FIFO protection:
  - A write while the corresponding fullflag is high is suppressed and sets err[0].
  - A read while the corresponding empty flag is high is suppressed and sets err[1].
- err bits clear only on rst.
- busy = 1 in FLUSH, FILL0, FILL1, RUN, and while a tap is pending in the pipeline.

Optional Feature:
- Macro: LBC_BORDER_REPLICATE_EN.
- Defined: tap_vld is also asserted for line 0 (all three taps = pixel) and line 1 (tap_row0 = tap_row1 = f0_rd_data). The downstream stage therefore sees IMG_HEIGHT tap lines.
- Undefined: taps are produced only for lines 2..IMG_HEIGHT-1, i.e. IMG_HEIGHT-2 tap lines.

Decomposition:
- Shared package lbc_pkg:
  - state enum: IDLE, FLUSH, FILL0, FILL1, RUN, DONE.
  - err bit index constants.
  - function computing CNT_W from IMG_WIDTH.
- One sub-module: lbc_pos_cnt, the column/row counter with wrap and end-of-line/end-of-frame strobes.

Test Plan:
- Reset -> fifo_rst=1, tap_vld=0, err=0. Then sof -> fifo_rst high exactly 4 cycles, then state FILL0.
- IMG_WIDTH=4, IMG_HEIGHT=4, continuous pixels 0..15 -> 8 tap_vld cycles:
  - first taps (row0, row1, row2) = (0, 4, 8), tap_row=2, tap_col=0;
  - last taps = (7, 11, 15).
- Same image with pix_vld toggling 1/0 -> identical tap sequence. Each tap_vld occurs 2 cycles after its pixel's pix_vld.
- sof mid-line 2 -> no further tap_vld, fifo_rst pulse. A following full frame produces correct taps starting at (0, 4, 8).
- Forced f0_empty=1 during FILL1 -> f0_rd_en is suppressed and err[1] stays set until rst. pix_vld during FLUSH -> err[0]=1.
- With LBC_BORDER_REPLICATE_EN, 4x4 frame -> 16 tap_vld cycles; first = (0, 0, 0), line-1 first = (0, 0, 4).
